// File: rtl/elevator_car_sched.sv
// SCAN-scheduled elevator car: consumes a request bitmap, moves one floor per
// TRAVEL_TICKS prescaled ticks, dwells with the door open and homes when idle.
module elevator_car_sched #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int TICK_DIV     = 1000000,
  parameter int TRAVEL_TICKS = 1,
  parameter int DWELL_TICKS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    default_floor,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  svc_valid,
  output logic [FLOOR_W-1:0]    svc_floor
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int CNT_MAX = (TRAVEL_TICKS > DWELL_TICKS) ? TRAVEL_TICKS : DWELL_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MOVE,
    S_HOME,
    S_DOOR
  } state_e;

  state_e              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                arrived_q, arrived_d;
  logic [FLOOR_W-1:0]  home_q, home_d;
  logic                svc_valid_q, svc_valid_d;
  logic [FLOOR_W-1:0]  svc_floor_q, svc_floor_d;

  logic               tick;
  logic [CNT_W-1:0]   cnt_inc;
  logic               travel_done;
  logic               at_end;
  logic               ahead_up, ahead_dn, here;
  logic [FLOOR_W-1:0] home_cl;

  assign home_cl     = (32'(default_floor) > 32'(NUM_FLOORS - 1)) ? TOP_FLOOR : default_floor;
  assign tick        = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
  assign cnt_inc     = cnt_q + 1'b1;
  assign travel_done = tick && (cnt_inc == CNT_W'(TRAVEL_TICKS));
  assign at_end      = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
  assign here        = req[floor_q];

  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_q)) ahead_up = ahead_up | req[i];
      if (i < int'(floor_q)) ahead_dn = ahead_dn | req[i];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    arrived_d   = 1'b0;
    home_d      = home_q;
    svc_valid_d = 1'b0;
    svc_floor_d = svc_floor_q;

    unique case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d     = S_DOOR;
          cnt_d       = '0;
          svc_valid_d = 1'b1;
          svc_floor_d = floor_q;
        end else if (ahead_up || ahead_dn) begin
          state_d = S_PREP;
        end else if (floor_q != home_cl) begin
          state_d = S_HOME;
          home_d  = home_cl;
          cnt_d   = '0;
        end
      end

      S_PREP: begin
        dir_d   = dir_q ? (ahead_up | ~ahead_dn) : (~ahead_dn & ahead_up);
        cnt_d   = '0;
        state_d = (ahead_up || ahead_dn) ? S_MOVE : S_IDLE;
      end

      S_MOVE: begin
        // The clk after a floor update is spent deciding whether to stop there.
        if (arrived_q) begin
          if (here) begin
            state_d     = S_DOOR;
            cnt_d       = '0;
            svc_valid_d = 1'b1;
            svc_floor_d = floor_q;
          end else if (!(dir_q ? ahead_up : ahead_dn)) begin
            state_d = S_PREP;
          end
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (travel_done) begin
            cnt_d = '0;
            if (at_end) begin
              state_d = S_PREP;
            end else begin
              floor_d   = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
              arrived_d = 1'b1;
            end
          end
        end
      end

      S_HOME: begin
        if (tick) begin
          cnt_d = cnt_inc;
          if (travel_done) begin
            cnt_d   = '0;
            floor_d = (home_q > floor_q) ? floor_q + 1'b1 : floor_q - 1'b1;
            if ((floor_d == home_q) || (|req)) state_d = S_IDLE;
          end
        end
      end

      S_DOOR: begin
        if (door_hold) begin
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DWELL_TICKS)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      floor_q     <= home_cl;
      dir_q       <= 1'b0;
      tick_cnt_q  <= '0;
      cnt_q       <= '0;
      arrived_q   <= 1'b0;
      home_q      <= home_cl;
      svc_valid_q <= 1'b0;
      svc_floor_q <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      tick_cnt_q  <= tick_cnt_d;
      cnt_q       <= cnt_d;
      arrived_q   <= arrived_d;
      home_q      <= home_d;
      svc_valid_q <= svc_valid_d;
      svc_floor_q <= svc_floor_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_q;
  assign moving        = (state_q == S_MOVE) || (state_q == S_HOME);
  assign door_open     = (state_q == S_DOOR);
  assign svc_valid     = svc_valid_q;
  assign svc_floor     = svc_floor_q;

endmodule
